mux_nx1_rr: RTL and testbench

//  Parametrised N-input, W-bit multiplexer with a registered output and a valid/ready handshake
//  on every input channel and on the output.

---
 rtl/mux_pkg.sv | 7 +
 rtl/rr_arbiter_n.sv | 44 ++++
 rtl/mux_nx1_rr.sv | 88 ++++++++
 tb/tb_mux_nx1_rr.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the N-to-1 valid/ready multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr, with wrap.
module rr_arbiter_n #(
    parameter  int N     = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             found
);

    logic [SEL_W-1:0] ptr;
    int               scan_idx;

    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int off = 0; off < N; off++) begin
            scan_idx = int'(ptr) + off;
            if (scan_idx >= N) scan_idx = scan_idx - N;
            if (!found && req[scan_idx]) begin
                found         = 1'b1;
                gnt_idx       = SEL_W'(scan_idx);
                gnt[scan_idx] = 1'b1;
            end
        end
    end

    // Pointer moves just past the granted channel, so that channel has lowest priority next.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr <= '0;
        end else if (en && found) begin
            if (gnt_idx == SEL_W'(N - 1)) ptr <= '0;
            else                          ptr <= gnt_idx + SEL_W'(1);
        end
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-input W-bit multiplexer with fixed or round-robin channel selection and one output register.
// Handshake: a word moves when valid && ready on the same rising edge; valid never waits on ready.
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int W     = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [N*W-1:0]   I,
    input  logic [N-1:0]     I_valid,
    output logic [N-1:0]     I_ready,
    input  logic [SEL_W-1:0] Sel,
    input  logic             Mode,
    output logic [W-1:0]     y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [SEL_W-1:0] y_chan
);

    localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

    logic [N-1:0]     rr_gnt;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_found;
    logic [SEL_W:0]   sel_ext;
    logic [SEL_W-1:0] cand;
    logic             cand_found;
    logic             load_en;
    logic             xfer;
    logic [W-1:0]     cand_word;

    assign load_en = !y_valid || y_ready;
    assign sel_ext = {1'b0, Sel};

    rr_arbiter_n #(.N(N)) u_arb (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .req     (I_valid),
        .en      (xfer && (Mode == MODE_RR)),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .found   (rr_found)
    );

    // An out-of-range Sel leaves no candidate, so nothing is offered a ready.
    always_comb begin
        cand       = '0;
        cand_found = 1'b0;
        if (Mode == MODE_RR) begin
            cand       = rr_idx;
            cand_found = rr_found;
        end else begin
            cand       = Sel;
            cand_found = (sel_ext < N_EXT);
        end
    end

    always_comb begin
        I_ready = '0;
        if (Reset_n && load_en && cand_found) begin
            if (Mode == MODE_RR) I_ready = rr_gnt;
            else                 I_ready[cand] = 1'b1;
        end
    end

    assign xfer      = |(I_valid & I_ready);
    assign cand_word = I[int'(cand)*W +: W];

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            y       <= '0;
            y_chan  <= '0;
            y_valid <= 1'b0;
        end else if (load_en) begin
            if (xfer) begin
                y       <= cand_word;
                y_chan  <= cand;
                y_valid <= 1'b1;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr: N=8 main instance plus an N=6 instance for out-of-range select.
module tb_mux_nx1_rr;
    import mux_pkg::*;

    logic        Clock;
    logic        Reset_n;

    logic [63:0] I;
    logic [7:0]  I_valid;
    logic [7:0]  I_ready;
    logic [2:0]  Sel;
    logic        Mode;
    logic [7:0]  y;
    logic        y_valid;
    logic        y_ready;
    logic [2:0]  y_chan;

    logic [47:0] I6;
    logic [5:0]  I_valid6;
    logic [5:0]  I_ready6;
    logic [2:0]  Sel6;
    logic        Mode6;
    logic [7:0]  y6;
    logic        y_valid6;
    logic        y_ready6;
    logic [2:0]  y_chan6;

    int          errors = 0;
    int          checks = 0;
    logic [10:0] exp_q[$];

    mux_nx1_rr #(.N(8), .W(8)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .I(I), .I_valid(I_valid), .I_ready(I_ready),
        .Sel(Sel), .Mode(Mode), .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_chan(y_chan)
    );

    mux_nx1_rr #(.N(6), .W(8)) dut6 (
        .Clock(Clock), .Reset_n(Reset_n), .I(I6), .I_valid(I_valid6), .I_ready(I_ready6),
        .Sel(Sel6), .Mode(Mode6), .y(y6), .y_valid(y_valid6), .y_ready(y_ready6), .y_chan(y_chan6)
    );

    // Clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] word(input int k, input int salt);
        return 8'((salt << 4) | k);
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load_pattern(input int salt);
        for (int k = 0; k < 8; k++) I[k*8 +: 8] = word(k, salt);
    endtask

    task automatic load_pattern6(input int salt);
        for (int k = 0; k < 6; k++) I6[k*8 +: 8] = word(k, salt);
    endtask

    task automatic push_exp(input int k, input logic [7:0] d);
        exp_q.push_back({3'(k), d});
    endtask

    // Scoreboard: each word consumed by the sink must match the oldest expected entry
    always @(negedge Clock) begin
        if (Reset_n && y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_word: observed=%0h expected=none", {y_chan, y});
            end else begin
                chk("y_word", 32'({y_chan, y}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int rr_seq[4];
        logic [7:0] held;
        rr_seq = '{2, 5, 7, 2};

        Reset_n  = 1'b0;
        Mode     = MODE_RR;
        Sel      = '0;
        I_valid  = 8'hFF;
        y_ready  = 1'b0;
        load_pattern(1);
        Mode6    = MODE_RR;
        Sel6     = '0;
        I_valid6 = '0;
        y_ready6 = 1'b0;
        load_pattern6(1);
        #2;
        chk("reset_y", 32'(y), 0);
        chk("reset_y_valid", 32'(y_valid), 0);
        chk("reset_y_chan", 32'(y_chan), 0);
        chk("reset_i_ready", 32'(I_ready), 0);

        // Load a word, then reset asynchronously while it is held
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        Mode    = MODE_FIXED;
        Sel     = 3'd1;
        #2;
        chk("fixed_sel1_ready", 32'(I_ready), 32'h02);
        tick();
        chk("held_valid", 32'(y_valid), 1);
        chk("held_y", 32'(y), 32'(word(1, 1)));
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_reset_y", 32'(y), 0);
        chk("async_reset_valid", 32'(y_valid), 0);
        chk("async_reset_chan", 32'(y_chan), 0);
        chk("async_reset_ready", 32'(I_ready), 0);
        #1;
        Reset_n = 1'b1;
        Mode    = MODE_RR;
        I_valid = 8'hFF;
        y_ready = 1'b1;
        #2;
        chk("rr_after_reset_ready", 32'(I_ready), 32'h01);
        push_exp(0, word(0, 1));
        tick();

        // Fixed select of channel 3
        Mode = MODE_FIXED;
        Sel  = 3'd3;
        I[3*8 +: 8] = 8'hA5;
        #2;
        chk("fixed_sel3_ready", 32'(I_ready), 32'h08);
        push_exp(3, 8'hA5);
        tick();
        chk("fixed_sel3_y", 32'(y), 32'hA5);
        chk("fixed_sel3_chan", 32'(y_chan), 3);

        // Round-robin over a sparse valid set, pointer starts past channel 0
        Mode    = MODE_RR;
        I_valid = 8'b1010_0100;
        load_pattern(3);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("rr_seq_ready", 32'(I_ready), 32'(1) << rr_seq[i]);
            push_exp(rr_seq[i], word(rr_seq[i], 3));
            tick();
        end

        // Backpressure with changing inputs
        I_valid = 8'hFF;
        load_pattern(4);
        #2;
        chk("bp_first_ready", 32'(I_ready), 32'h08);
        push_exp(3, word(3, 4));
        tick();
        held    = word(3, 4);
        y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_pattern(5 + i);
            I_valid = 8'($urandom_range(1, 255));
            #2;
            chk("bp_ready_zero", 32'(I_ready), 0);
            chk("bp_y_stable", 32'(y), 32'(held));
            chk("bp_chan_stable", 32'(y_chan), 3);
            chk("bp_valid_held", 32'(y_valid), 1);
            tick();
        end
        y_ready = 1'b1;
        I_valid = 8'hFF;
        load_pattern(9);
        #2;
        chk("bp_release_ready", 32'(I_ready), 32'h10);
        push_exp(4, word(4, 9));
        tick();
        chk("bp_reload_valid", 32'(y_valid), 1);
        chk("bp_reload_y", 32'(y), 32'(word(4, 9)));

        // Drain with nothing valid: valid drops, data and channel hold
        I_valid = '0;
        #2;
        chk("idle_ready", 32'(I_ready), 0);
        tick();
        chk("drain_valid", 32'(y_valid), 0);
        chk("drain_y_hold", 32'(y), 32'(word(4, 9)));
        chk("drain_chan_hold", 32'(y_chan), 4);

        // Fixed select of an invalid channel while others are valid
        Mode    = MODE_FIXED;
        Sel     = 3'd2;
        I_valid = 8'b1111_1011;
        #2;
        chk("fixed_invalid_ready", 32'(I_ready), 32'h04);
        tick();
        chk("fixed_invalid_no_load", 32'(y_valid), 0);
        y_ready = 1'b0;
        I_valid = '0;

        // N=6: out-of-range select, then RR resumes at the preserved pointer
        Mode6    = MODE_RR;
        I_valid6 = 6'b00_1000;
        y_ready6 = 1'b1;
        load_pattern6(10);
        #2;
        chk("n6_rr_ready3", 32'(I_ready6), 32'h08);
        tick();
        chk("n6_y3", 32'(y6), 32'(word(3, 10)));
        chk("n6_chan3", 32'(y_chan6), 3);
        Mode6    = MODE_FIXED;
        Sel6     = 3'd7;
        I_valid6 = 6'h3F;
        #2;
        chk("n6_sel7_ready", 32'(I_ready6), 0);
        tick();
        chk("n6_sel7_drained", 32'(y_valid6), 0);
        Mode6 = MODE_RR;
        #2;
        chk("n6_rr_ptr4_ready", 32'(I_ready6), 32'h10);
        tick();
        chk("n6_chan4", 32'(y_chan6), 4);
        chk("n6_y4", 32'(y6), 32'(word(4, 10)));
        chk("n6_valid4", 32'(y_valid6), 1);
        I_valid6 = 6'b00_0011;
        #2;
        chk("n6_wrap_ready", 32'(I_ready6), 32'h01);
        tick();
        chk("n6_wrap_chan", 32'(y_chan6), 0);
        y_ready6 = 1'b0;
        I_valid6 = '0;
        tick();

        // Final report
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
